// File: rtl/tcam_request_scheduler.sv
// Multi-channel round-robin front-end for a single TCAM core: one holding
// register per client, one operation in flight, watchdog-protected responses.
module tcam_request_scheduler #(
  parameter int CHANNELS  = 4,
  parameter int CH_BITS   = 2,
  parameter int KWID      = 10,
  parameter int IDWID     = 2,
  parameter int MASKWID   = 5,
  parameter int TO_CYCLES = 255,
  parameter int TO_BITS   = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [CHANNELS-1:0]         REQ_VALID,
  output logic [CHANNELS-1:0]         REQ_READY,
  input  logic [CHANNELS-1:0]         REQ_OP,
  input  logic [CHANNELS*KWID-1:0]    REQ_KEY,
  input  logic [CHANNELS*IDWID-1:0]   REQ_ID,
  input  logic [CHANNELS*IDWID-1:0]   REQ_PRIORITY,
  input  logic [CHANNELS*MASKWID-1:0] REQ_MASKID,
  output logic                        CORE_SEARCH,
  output logic                        CORE_SETTING,
  output logic [KWID-1:0]             CORE_KEY,
  output logic [IDWID-1:0]            CORE_SETTING_ID,
  output logic [MASKWID-1:0]          CORE_SETTING_MASKID,
  output logic [IDWID-1:0]            CORE_SETTING_PRIORITY,
  input  logic [IDWID-1:0]            CORE_RULEID,
  input  logic                        CORE_MISMATCH,
  input  logic                        CORE_SEARCH_COMPLETE,
  input  logic                        CORE_SETTING_COMPLETE,
  output logic                        RSP_VALID,
  output logic [CH_BITS-1:0]          RSP_CH,
  output logic                        RSP_OP,
  output logic [IDWID-1:0]            RSP_RULEID,
  output logic                        RSP_MISMATCH,
  output logic                        RSP_TIMEOUT,
  output logic                        BUSY
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CH_BITS-1:0] CH_ONE  = CH_BITS'(1);
  localparam logic [CH_BITS-1:0] CH_LAST = CH_BITS'(CHANNELS - 1);
  localparam logic [TO_BITS-1:0] TO_ONE  = TO_BITS'(1);
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TO_CYCLES - 1);

  state_t               state;
  logic [CHANNELS-1:0]  held_valid;
  logic [CHANNELS-1:0]  held_op;
  logic [KWID-1:0]      held_key    [CHANNELS];
  logic [IDWID-1:0]     held_id     [CHANNELS];
  logic [IDWID-1:0]     held_pri    [CHANNELS];
  logic [MASKWID-1:0]   held_mask   [CHANNELS];
  logic [CH_BITS-1:0]   rr;
  logic [CH_BITS-1:0]   g;
  logic                 cur_op;
  logic [TO_BITS-1:0]   wd;
  logic [CH_BITS-1:0]   grant;
  logic [CH_BITS-1:0]   cand;
  logic                 grant_found;
  logic                 done;

  assign REQ_READY = ~held_valid;
  assign done      = cur_op ? CORE_SETTING_COMPLETE : CORE_SEARCH_COMPLETE;

  // Round-robin search from rr upward; scanning from the far end keeps the nearest hit.
  always_comb begin
    grant       = rr;
    grant_found = 1'b0;
    cand        = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      cand = (int'(rr) + i >= CHANNELS) ? CH_BITS'(int'(rr) + i - CHANNELS)
                                        : CH_BITS'(int'(rr) + i);
      grant       = held_valid[cand] ? cand : grant;
      grant_found = grant_found | held_valid[cand];
    end
  end

  // Per-channel holding registers: capture on handshake, release after the response.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      held_valid <= '0;
      held_op    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        held_key[c]  <= '0;
        held_id[c]   <= '0;
        held_pri[c]  <= '0;
        held_mask[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (REQ_VALID[c] && !held_valid[c]) begin
          held_valid[c] <= 1'b1;
          held_op[c]    <= REQ_OP[c];
          held_key[c]   <= REQ_KEY[c*KWID +: KWID];
          held_id[c]    <= REQ_ID[c*IDWID +: IDWID];
          held_pri[c]   <= REQ_PRIORITY[c*IDWID +: IDWID];
          held_mask[c]  <= REQ_MASKID[c*MASKWID +: MASKWID];
        end
      end
      if (state == RESP) begin
        held_valid[g] <= 1'b0;
      end
    end
  end

  // Control FSM with registered core strobes, operands and response fields.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state                 <= IDLE;
      rr                    <= '0;
      g                     <= '0;
      cur_op                <= 1'b0;
      wd                    <= '0;
      CORE_SEARCH           <= 1'b0;
      CORE_SETTING          <= 1'b0;
      CORE_KEY              <= '0;
      CORE_SETTING_ID       <= '0;
      CORE_SETTING_MASKID   <= '0;
      CORE_SETTING_PRIORITY <= '0;
      RSP_VALID             <= 1'b0;
      RSP_CH                <= '0;
      RSP_OP                <= 1'b0;
      RSP_RULEID            <= '0;
      RSP_MISMATCH          <= 1'b0;
      RSP_TIMEOUT           <= 1'b0;
      BUSY                  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            g                     <= grant;
            cur_op                <= held_op[grant];
            CORE_SEARCH           <= ~held_op[grant];
            CORE_SETTING          <= held_op[grant];
            CORE_KEY              <= held_key[grant];
            CORE_SETTING_ID       <= held_id[grant];
            CORE_SETTING_MASKID   <= held_mask[grant];
            CORE_SETTING_PRIORITY <= held_pri[grant];
            BUSY                  <= 1'b1;
            state                 <= ISSUE;
          end
        end
        ISSUE: begin
          CORE_SEARCH  <= 1'b0;
          CORE_SETTING <= 1'b0;
          wd           <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          // A completion in the final watchdog cycle still wins over the timeout.
          if (done) begin
            RSP_VALID    <= 1'b1;
            RSP_CH       <= g;
            RSP_OP       <= cur_op;
            RSP_RULEID   <= cur_op ? '0 : CORE_RULEID;
            RSP_MISMATCH <= CORE_MISMATCH;
            RSP_TIMEOUT  <= 1'b0;
            state        <= RESP;
          end else if (wd == TO_LAST) begin
            RSP_VALID    <= 1'b1;
            RSP_CH       <= g;
            RSP_OP       <= cur_op;
            RSP_RULEID   <= '0;
            RSP_MISMATCH <= 1'b1;
            RSP_TIMEOUT  <= 1'b1;
            state        <= RESP;
          end else begin
            wd <= wd + TO_ONE;
          end
        end
        RESP: begin
          RSP_VALID <= 1'b0;
          rr        <= (g == CH_LAST) ? '0 : g + CH_ONE;
          BUSY      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_request_scheduler.sv
// Directed bench for tcam_request_scheduler: a cycle-by-cycle vector table plus
// hand-written sequences for fairness, wrap-around, watchdog and reset.
module tb_tcam_request_scheduler;

  logic        CLK;
  logic        RESET;
  logic [3:0]  req_valid, req_ready, req_op;
  logic [39:0] req_key;
  logic [7:0]  req_id, req_priority;
  logic [19:0] req_maskid;
  logic        core_search, core_setting;
  logic [9:0]  core_key;
  logic [1:0]  core_setting_id, core_setting_priority;
  logic [4:0]  core_setting_maskid;
  logic [1:0]  core_ruleid;
  logic        core_mismatch;
  logic        core_search_complete, core_setting_complete;
  logic        rsp_valid, rsp_op, rsp_mismatch, rsp_timeout, busy;
  logic [1:0]  rsp_ch, rsp_ruleid;

  logic man_sc, man_stc, auto_sc, auto_stc, auto_en;
  int   n_cmp, n_err, cyc, issue_cyc;
  int   q_ch[$], q_op[$], q_rule[$], q_mm[$], q_to[$], q_cyc[$];

  assign core_search_complete  = man_sc | auto_sc;
  assign core_setting_complete = man_stc | auto_stc;

  tcam_request_scheduler #(
    .CHANNELS(4), .CH_BITS(2), .KWID(10), .IDWID(2), .MASKWID(5),
    .TO_CYCLES(8), .TO_BITS(4)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op),
    .REQ_KEY(req_key), .REQ_ID(req_id), .REQ_PRIORITY(req_priority),
    .REQ_MASKID(req_maskid),
    .CORE_SEARCH(core_search), .CORE_SETTING(core_setting), .CORE_KEY(core_key),
    .CORE_SETTING_ID(core_setting_id), .CORE_SETTING_MASKID(core_setting_maskid),
    .CORE_SETTING_PRIORITY(core_setting_priority),
    .CORE_RULEID(core_ruleid), .CORE_MISMATCH(core_mismatch),
    .CORE_SEARCH_COMPLETE(core_search_complete),
    .CORE_SETTING_COMPLETE(core_setting_complete),
    .RSP_VALID(rsp_valid), .RSP_CH(rsp_ch), .RSP_OP(rsp_op), .RSP_RULEID(rsp_ruleid),
    .RSP_MISMATCH(rsp_mismatch), .RSP_TIMEOUT(rsp_timeout), .BUSY(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Core model for the automatic sequences: completes in the first WAIT cycle.
  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    auto_sc  <= auto_en & core_search;
    auto_stc <= auto_en & core_setting;
  end

  // Response and strobe monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (core_search || core_setting) issue_cyc = cyc;
    if (rsp_valid) begin
      q_ch.push_back(int'(rsp_ch));
      q_op.push_back(int'(rsp_op));
      q_rule.push_back(int'(rsp_ruleid));
      q_mm.push_back(int'(rsp_mismatch));
      q_to.push_back(int'(rsp_timeout));
      q_cyc.push_back(cyc);
    end
  end

  typedef struct {
    int         ch;   logic v;    logic op;   logic [9:0] key;
    logic [1:0] id;   logic [1:0] pr;  logic [4:0] mk;
    logic sc; logic stc; logic [1:0] cr; logic cm;
    logic [3:0] e_ready; logic e_busy; logic e_cs; logic e_cst;
    logic [9:0] e_key; logic [1:0] e_id; logic [4:0] e_mk; logic [1:0] e_pr;
    logic e_rv; logic [1:0] e_rch; logic e_rop; logic [1:0] e_rrule; logic e_rmm; logic e_rto;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_op = '0; req_key = '0; req_id = '0;
    req_priority = '0; req_maskid = '0;
    man_sc = 1'b0; man_stc = 1'b0; core_ruleid = '0; core_mismatch = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'hF);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_core"}, {11'(core_key), 1'(core_search), 1'(core_setting),
        2'(core_setting_id), 5'(core_setting_maskid), 2'(core_setting_priority)}, 32'h0);
    chk({tag, "_rsp"}, {2'(rsp_ch), 1'(rsp_valid), 1'(rsp_op), 2'(rsp_ruleid),
        1'(rsp_mismatch), 1'(rsp_timeout)}, 32'h0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    q_ch.delete(); q_op.delete(); q_rule.delete();
    q_mm.delete(); q_to.delete(); q_cyc.delete();
  endtask

  task automatic wait_rsp(input string name, input int n, input int budget);
    for (int k = 0; k < budget && q_ch.size() < n; k++) tick();
    chk(name, 32'(q_ch.size()), 32'(n));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; issue_cyc = 0;
    auto_en = 1'b0; auto_sc = 1'b0; auto_stc = 1'b0;
    clear_inputs();
    RESET = 1'b1;
    tick();
    tick();
    chk_reset("reset");
    RESET = 1'b0;

    // Row k drives cycle k; expectations are the outputs in cycle k+1.
    //             ch v op key     id    pr    mk     sc   stc  cr    cm    ready  bsy cs   cst  key     id    mk     pr    rv   rch   rop  rule  mm   to
    tbl.push_back('{2, 1, 0, 10'h2A5, 2'd0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'hB, 0, 1'b0, 1'b0, 10'h000, 2'd0, 5'h00, 2'd0, 1'b0, 2'd0, 0, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'hB, 1, 1'b1, 1'b0, 10'h2A5, 2'd0, 5'h00, 2'd0, 1'b0, 2'd0, 0, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'hB, 1, 1'b0, 1'b0, 10'h2A5, 2'd0, 5'h00, 2'd0, 1'b0, 2'd0, 0, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'hB, 1, 1'b0, 1'b0, 10'h2A5, 2'd0, 5'h00, 2'd0, 1'b0, 2'd0, 0, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'hB, 1, 1'b0, 1'b0, 10'h2A5, 2'd0, 5'h00, 2'd0, 1'b0, 2'd0, 0, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b1, 1'b0, 2'd3, 1'b0, 4'hB, 1, 1'b0, 1'b0, 10'h2A5, 2'd0, 5'h00, 2'd0, 1'b1, 2'd2, 0, 2'd3, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'hF, 0, 1'b0, 1'b0, 10'h2A5, 2'd0, 5'h00, 2'd0, 1'b0, 2'd0, 0, 2'd0, 0, 0});
    tbl.push_back('{1, 1, 1, 10'h155, 2'd2, 2'd1, 5'h13, 1'b0, 1'b0, 2'd0, 1'b0, 4'hD, 0, 1'b0, 1'b0, 10'h2A5, 2'd0, 5'h00, 2'd0, 1'b0, 2'd0, 0, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'hD, 1, 1'b0, 1'b1, 10'h155, 2'd2, 5'h13, 2'd1, 1'b0, 2'd0, 0, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'hD, 1, 1'b0, 1'b0, 10'h155, 2'd2, 5'h13, 2'd1, 1'b0, 2'd0, 0, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b1, 1'b0, 2'd1, 1'b1, 4'hD, 1, 1'b0, 1'b0, 10'h155, 2'd2, 5'h13, 2'd1, 1'b0, 2'd0, 0, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b0, 1'b1, 2'd3, 1'b0, 4'hD, 1, 1'b0, 1'b0, 10'h155, 2'd2, 5'h13, 2'd1, 1'b1, 2'd1, 1, 2'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 10'h000, 2'd0, 2'd0, 5'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'hF, 0, 1'b0, 1'b0, 10'h155, 2'd2, 5'h13, 2'd1, 1'b0, 2'd0, 0, 2'd0, 0, 0});

    foreach (tbl[r]) begin
      clear_inputs();
      req_valid[tbl[r].ch]                 = tbl[r].v;
      req_op[tbl[r].ch]                    = tbl[r].op;
      req_key[tbl[r].ch*10 +: 10]          = tbl[r].key;
      req_id[tbl[r].ch*2 +: 2]             = tbl[r].id;
      req_priority[tbl[r].ch*2 +: 2]       = tbl[r].pr;
      req_maskid[tbl[r].ch*5 +: 5]         = tbl[r].mk;
      man_sc = tbl[r].sc; man_stc = tbl[r].stc;
      core_ruleid = tbl[r].cr; core_mismatch = tbl[r].cm;
      tick();
      chk($sformatf("row%0d_ready", r), 32'(req_ready), 32'(tbl[r].e_ready));
      chk($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].e_busy));
      chk($sformatf("row%0d_search", r), 32'(core_search), 32'(tbl[r].e_cs));
      chk($sformatf("row%0d_setting", r), 32'(core_setting), 32'(tbl[r].e_cst));
      chk($sformatf("row%0d_key", r), 32'(core_key), 32'(tbl[r].e_key));
      chk($sformatf("row%0d_sid", r), 32'(core_setting_id), 32'(tbl[r].e_id));
      chk($sformatf("row%0d_smask", r), 32'(core_setting_maskid), 32'(tbl[r].e_mk));
      chk($sformatf("row%0d_sprio", r), 32'(core_setting_priority), 32'(tbl[r].e_pr));
      chk($sformatf("row%0d_rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].e_rv));
      if (tbl[r].e_rv) begin
        chk($sformatf("row%0d_rsp_fields", r),
            {27'(rsp_ch), 1'(rsp_op), 2'(rsp_ruleid), 1'(rsp_mismatch), 1'(rsp_timeout)},
            {27'(tbl[r].e_rch), 1'(tbl[r].e_rop), 2'(tbl[r].e_rrule), 1'(tbl[r].e_rmm), 1'(tbl[r].e_rto)});
      end
    end
    clear_inputs();

    // Fairness: all channels kept loaded; grants must rotate 0,1,2,3 at 4 cycles each.
    do_reset();
    auto_en = 1'b1;
    req_valid = 4'hF;
    req_op    = 4'b1010;
    wait_rsp("rr_count", 8, 100);
    req_valid = '0;
    for (int i = 0; i < 8 && i < q_ch.size(); i++) begin
      chk($sformatf("rr_ch%0d", i), 32'(q_ch[i]), 32'(i % 4));
      chk($sformatf("rr_op%0d", i), 32'(q_op[i]), 32'((i % 4) & 1));
      if (i > 0) chk($sformatf("rr_period%0d", i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd4);
    end

    // Wrap-around: serve channel 2 so rr=3, then load 1 and 3 together.
    do_reset();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_rsp("wrap_first", 1, 40);
    req_valid = 4'b1010;
    tick();
    req_valid = '0;
    wait_rsp("wrap_count", 3, 60);
    if (q_ch.size() >= 3) begin
      chk("wrap_order_a", 32'(q_ch[1]), 32'd3);
      chk("wrap_order_b", 32'(q_ch[2]), 32'd1);
    end
    auto_en = 1'b0;
    repeat (3) tick();

    // Watchdog: no completion, response at ISSUE+9, late completion ignored.
    do_reset();
    req_valid = 4'b0001;
    req_key[9:0] = 10'h3FF;
    tick();
    req_valid = '0;
    wait_rsp("wd_count", 1, 40);
    if (q_ch.size() >= 1) begin
      chk("wd_latency", 32'(q_cyc[0] - issue_cyc), 32'd9);
      chk("wd_timeout", 32'(q_to[0]), 32'd1);
      chk("wd_mismatch", 32'(q_mm[0]), 32'd1);
      chk("wd_ruleid", 32'(q_rule[0]), 32'd0);
    end
    tick();
    core_ruleid = 2'd2;
    man_sc = 1'b1;
    tick();
    man_sc = 1'b0;
    repeat (12) tick();
    chk("wd_late_ignored", 32'(q_ch.size()), 32'd1);
    chk("wd_idle_busy", 32'(busy), 32'd0);

    // Reset while in WAIT abandons the request.
    do_reset();
    req_valid = 4'b1000;
    req_key[39:30] = 10'h0F0;
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_ready", 32'(req_ready), 32'h7);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_reset("mid_reset");
    man_sc = 1'b1;
    tick();
    man_sc = 1'b0;
    repeat (12) tick();
    chk("mid_no_rsp", 32'(q_ch.size()), 32'd0);
    chk("mid_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
